// File: rtl/semaphore_pkg.sv
// Shared definitions for the traffic-light controller and its monitor:
// phase encodings, default dwell lengths, error-flag bit positions and
// small decode helpers.
package semaphore_pkg;

    typedef enum logic [1:0] {
        PH_DARK   = 2'd0,
        PH_RED    = 2'd1,
        PH_YELLOW = 2'd2,
        PH_GREEN  = 2'd3
    } phase_e;

    localparam int unsigned RED_CYC_DEF    = 51;
    localparam int unsigned YELLOW_CYC_DEF = 11;
    localparam int unsigned GREEN_CYC_DEF  = 31;

    localparam int unsigned DWELL_W = 8;

    // Bit positions inside err_flags
    localparam int unsigned ERR_MULTI = 0;
    localparam int unsigned ERR_SEQ   = 1;
    localparam int unsigned ERR_TIME  = 2;
    localparam int unsigned ERR_START = 3;

    // Phase indicated by a single-lamp sample (caller screens out multi-lamp).
    function automatic phase_e lamp_to_phase(input logic r, input logic y, input logic g);
        phase_e ph;
        if (r)      ph = PH_RED;
        else if (y) ph = PH_YELLOW;
        else if (g) ph = PH_GREEN;
        else        ph = PH_DARK;
        return ph;
    endfunction

    // Legal lamp-to-lamp steps; lit->dark is judged separately via enable history.
    function automatic logic legal_step(input phase_e from_ph, input phase_e to_ph);
        logic ok;
        ok = 1'b0;
        case (from_ph)
            PH_DARK:   ok = (to_ph == PH_RED);
            PH_RED:    ok = (to_ph == PH_YELLOW);
            PH_YELLOW: ok = (to_ph == PH_GREEN);
            PH_GREEN:  ok = (to_ph == PH_RED);
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/semaphore_dwell_cnt.sv
// Saturating dwell counter for the current lit phase.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   load          load load_val (takes priority over en)
//   load_val      value loaded on phase entry / exit
//   en            count one sample (stops at all-ones)
//   limit         expected dwell for the current phase
//   at_limit      count == limit
//   below_limit   count <  limit
//   sat           count is at its maximum
module semaphore_dwell_cnt
    import semaphore_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [DWELL_W-1:0] load_val,
    input  logic               en,
    input  logic [DWELL_W-1:0] limit,
    output logic               at_limit,
    output logic               below_limit,
    output logic               sat
);

    logic [DWELL_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && !sat) begin
            count <= count + 1'b1;
        end
    end

    assign sat         = (count == '1);
    assign at_limit    = (count == limit);
    assign below_limit = (count < limit);

endmodule

// File: rtl/semaphore_monitor.sv
// Passive checker for a red/yellow/green traffic-light controller.
// Tracks the lamp phase, checks sequencing, dwell time, start-up and
// lamp exclusivity, and counts completed green->red cycles.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   enable       enable driving the observed controller
//   red/yellow/green  observed lamps
//   clear        synchronous clear of err_flags and cycles
//   phase        current tracked phase (0 dark, 1 red, 2 yellow, 3 green)
//   err_flags    sticky {start, time, seq, multi}
//   err_pulse    one-cycle pulse on any newly detected error
//   cycles       completed green->red transitions, saturating
module semaphore_monitor
    import semaphore_pkg::*;
#(
    parameter int unsigned RED_CYC    = RED_CYC_DEF,
    parameter int unsigned YELLOW_CYC = YELLOW_CYC_DEF,
    parameter int unsigned GREEN_CYC  = GREEN_CYC_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       red,
    input  logic       yellow,
    input  logic       green,
    input  logic       clear,
    output logic [1:0] phase,
    output logic [3:0] err_flags,
    output logic       err_pulse,
    output logic [7:0] cycles
);

    phase_e             state_q, state_d;
    logic               en_prev_q;
    logic [1:0]         lamp_cnt;
    logic               multi, any_lit;
    phase_e             lit_ph;

    logic               dw_load, dw_en;
    logic [DWELL_W-1:0] dw_load_val, dw_limit;
    logic               dw_at_limit, dw_below, dw_sat;

    logic [3:0]         det;
    logic               cyc_inc;

    assign lamp_cnt = 2'(red) + 2'(yellow) + 2'(green);
    assign multi    = (lamp_cnt > 2'd1);
    assign any_lit  = red | yellow | green;
    assign lit_ph   = lamp_to_phase(red, yellow, green);

    always_comb begin
        dw_limit = '0;
        case (state_q)
            PH_RED:    dw_limit = DWELL_W'(RED_CYC);
            PH_YELLOW: dw_limit = DWELL_W'(YELLOW_CYC);
            PH_GREEN:  dw_limit = DWELL_W'(GREEN_CYC);
            default:   dw_limit = '0;
        endcase
    end

    semaphore_dwell_cnt u_dwell (
        .clk         (clk),
        .rst         (rst),
        .load        (dw_load),
        .load_val    (dw_load_val),
        .en          (dw_en),
        .limit       (dw_limit),
        .at_limit    (dw_at_limit),
        .below_limit (dw_below),
        .sat         (dw_sat)
    );

    // State register and enable history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= PH_DARK;
            en_prev_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            en_prev_q <= enable;
        end
    end

    // Next state: follow the lit lamp; a multi-lamp sample freezes state and dwell
    always_comb begin
        state_d     = state_q;
        dw_load     = 1'b0;
        dw_load_val = '0;
        dw_en       = 1'b0;
        if (!multi) begin
            if (lit_ph == state_q) begin
                dw_en = (state_q != PH_DARK);
            end else begin
                state_d     = lit_ph;
                dw_load     = 1'b1;
                dw_load_val = (lit_ph == PH_DARK) ? DWELL_W'(0) : DWELL_W'(1);
            end
        end
    end

    // Error detection for the current sample
    always_comb begin
        det     = '0;
        cyc_inc = 1'b0;
        if (multi) begin
            det[ERR_MULTI] = 1'b1;
        end else if (lit_ph == state_q) begin
            if (state_q == PH_DARK) begin
                det[ERR_START] = enable && en_prev_q;
            end else begin
                // Next sample would reach limit+1; fires once because the count moves past
                det[ERR_TIME] = dw_at_limit && !dw_sat;
            end
        end else begin
            if (lit_ph == PH_DARK) begin
                det[ERR_SEQ] = en_prev_q;
            end else begin
                det[ERR_SEQ] = !legal_step(state_q, lit_ph);
            end
            // Underrun is waived when enable was already low (controller abort)
            if (state_q != PH_DARK && dw_below && en_prev_q) begin
                det[ERR_TIME] = 1'b1;
            end
            cyc_inc = (state_q == PH_GREEN) && (lit_ph == PH_RED);
        end
        if (any_lit && !enable && !en_prev_q) begin
            det[ERR_SEQ] = 1'b1;
        end
    end

    // Registered outputs; a detection in the clear cycle survives the clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_flags <= '0;
            err_pulse <= 1'b0;
            cycles    <= '0;
        end else begin
            err_flags <= (clear ? 4'b0000 : err_flags) | det;
            err_pulse <= |det;
            if (clear) begin
                cycles <= {7'b0, cyc_inc};
            end else if (cyc_inc && cycles != 8'hFF) begin
                cycles <= cycles + 8'd1;
            end
        end
    end

    assign phase = state_q;

endmodule

// File: doc/semaphore_monitor.md
SEMAPHORE_MONITOR -- requirements
Module: semaphore_monitor

Interface
REQ-001 SHALL have parameter RED_CYC, default 51, meaning required red dwell in clock cycles.
REQ-002 SHALL have parameter YELLOW_CYC, default 11, meaning required yellow dwell in clock cycles.
REQ-003 SHALL have parameter GREEN_CYC, default 31, meaning required green dwell in clock cycles.
REQ-004 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 enable  in  1  the enable that drives the observed light controller.
REQ-007 red / yellow / green  in  1 each  observed lamp signals.
REQ-008 clear  in  1  synchronous clear of sticky errors and cycle count.
REQ-009 phase  out  2  decoded phase: 0 DARK, 1 RED, 2 YELLOW, 3 GREEN.
REQ-010 err_flags  out  4  sticky flags {start, time, seq, multi}, bit 3 to bit 0.
REQ-011 err_pulse  out  1  high for one cycle on any newly detected error.
REQ-012 cycles  out  8  count of completed green-to-red transitions, saturating at 255.

Function
REQ-013 SHALL sample all inputs on rising clk; every output SHALL be registered with one cycle of latency from the sampled cause.
REQ-014 SHALL track states DARK, RED, YELLOW, GREEN; phase SHALL equal the current state's encoding.
REQ-015 multi: more than one lamp lit in a sample -> set bit 0; state and dwell SHALL hold for that sample.
REQ-016 Legal transitions SHALL be DARK->RED, RED->YELLOW, YELLOW->GREEN and GREEN->RED; any other lamp change SHALL set bit 1 (seq), and the state SHALL follow the lit lamp.
REQ-017 Lit->dark SHALL be legal only if enable was low in the previous sample; otherwise it SHALL set bit 1.
REQ-018 A dwell counter (8 bits, saturating) SHALL count consecutive samples in the current lit phase and reload to 1 on phase entry.
REQ-019 Overrun: dwell reaching expected+1 while still lit SHALL set bit 2 (time) once per phase.
REQ-020 Underrun: leaving a phase with dwell < expected SHALL set bit 2, except when the phase ends through enable low (abort).
REQ-021 Any lamp lit while enable is low in both the current and previous sample SHALL set bit 1.
REQ-022 start: in DARK with enable high for 2 consecutive samples and no lamp lit SHALL set bit 3; 1 sample SHALL be legal.
REQ-023 cycles SHALL increment on each legal GREEN->RED transition and saturate at 255.
REQ-024 clear SHALL zero err_flags and cycles; a new error in the same cycle SHALL win and remain set; clear SHALL NOT affect state or dwell.
REQ-025 err_pulse SHALL assert whenever any flag is newly detected in that sample, even if it is already set.

Reset
REQ-026 rst high SHALL immediately force state DARK, phase 0, dwell 0, err_flags 0, err_pulse 0, cycles 0, and the enable history to 0.
REQ-027 Reset asserted mid-phase SHALL discard the phase with no error, and monitoring SHALL restart from DARK.

Structure
REQ-028 Phase encodings and default dwell constants SHALL live in shared package semaphore_pkg, used by both the controller and the monitor.
REQ-029 The dwell counter SHALL be sub-module semaphore_dwell_cnt (load, enable, saturate, compare-to-limit outputs).

Verification
REQ-030 Drive a legal controller sequence for 3 full cycles (enable high, R51/Y11/G31) -> err_flags 0, cycles 3, phase follows the lamps with one cycle of lag.
REQ-031 Hold yellow for 12 samples -> err_flags 4'b0100 set at sample 12, single err_pulse.
REQ-032 Go red->green directly -> err_flags 4'b0010, phase 3.
REQ-033 Light red+green together for 1 sample -> bit 0 set, state unchanged.
REQ-034 Drop enable at red dwell 20, lamp dark next sample -> no error; then raise enable with lamps dark for 2 samples -> bit 3 set.
REQ-035 Assert clear in the same cycle as a new overrun -> bit 2 stays set and cycles reads 0; apply 256 legal cycles -> cycles saturates at 255.
